z80_int_ctrl: RTL and testbench

Interrupt-control unit for the RISC core's Z80 emulation. Owns the IFF1/IFF2 interrupt flip-flops and the interrupt mode, which the execute-stage result mux reads for `mviff`. It also acts on EI/DI/RETN/IM retire pulses, detects NMI edges and maskable INT levels, and runs a request/acknowledge handshake with the fetch stage that supplies the vector PC.

---
 rtl/z80_int_pkg.sv | 23 ++
 rtl/int_sync2.sv | 50 +++++
 rtl/z80_int_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_z80_int_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/z80_int_pkg.sv
// Shared types and constants for the Z80 interrupt-control unit.
// Holds the FSM state enum, vector PCs, IM encodings and a mode helper.
package z80_int_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EI_WAIT = 2'd1,
        REQ     = 2'd2
    } int_state_e;

    localparam logic [15:0] NMI_VEC   = 16'h0066;
    localparam logic [15:0] RST38_VEC = 16'h0038;

    localparam logic [1:0] IM_0 = 2'd0;
    localparam logic [1:0] IM_1 = 2'd1;
    localparam logic [1:0] IM_2 = 2'd2;

    // Mode 3 does not exist on the Z80; it behaves as IM0.
    function automatic logic [1:0] im_norm(input logic [1:0] d);
        return (d == 2'd3) ? IM_0 : d;
    endfunction

endpackage

// File: rtl/int_sync2.sv
// Input sampler for one active-low interrupt line.
// Ports: clk, rst_n (sync, active low), i_d (raw line),
//        o_q (sampled value), o_prev (o_q one cycle earlier).
// Macro INT_SYNC_EN: insert a 2-flop synchronizer before the sampler.
module int_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_prev
);

    logic w_d;
    logic r_q;
    logic r_prev;

`ifdef INT_SYNC_EN
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign w_d = r_sync;
`else
    assign w_d = i_d;
`endif

    // Lines idle high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_q    <= w_d;
            r_prev <= r_q;
        end
    end

    assign o_q    = r_q;
    assign o_prev = r_prev;

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 interrupt control: IFF1/IFF2, IM, NMI/INT detect, fetch handshake.
// In: clk, rst_n, nmi_n, int_n, ei, di, retn, im_wr, im_data[1:0],
//     instr_retire, i_reg[7:0], vec_data[7:0], int_ack.
// Out: int_req, int_is_nmi, int_vector[15:0], IFF1, IFF2, im[1:0].
// Macro INT_SYNC_EN: adds 2-flop synchronizers on nmi_n and int_n.
module z80_int_ctrl
    import z80_int_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        int_n,
    input  logic        ei,
    input  logic        di,
    input  logic        retn,
    input  logic        im_wr,
    input  logic [1:0]  im_data,
    input  logic        instr_retire,
    input  logic [7:0]  i_reg,
    input  logic [7:0]  vec_data,
    input  logic        int_ack,
    output logic        int_req,
    output logic        int_is_nmi,
    output logic [15:0] int_vector,
    output logic        IFF1,
    output logic        IFF2,
    output logic [1:0]  im
);

    int_state_e  r_state;
    int_state_e  w_state_nx;
    logic        r_iff1, w_iff1_nx;
    logic        r_iff2, w_iff2_nx;
    logic [1:0]  r_im, w_im_nx;
    logic        r_req, w_req_nx;
    logic        r_is_nmi, w_is_nmi_nx;
    logic [15:0] r_vec, w_vec_nx;
    logic        r_nmi_pend, w_pend_nx;

    logic w_nmi_q, w_nmi_prev;
    logic w_int_q, w_int_prev;
    logic w_nmi_fall;
    logic w_int_lvl;
    logic w_ack;
    logic w_take_nmi;
    logic w_take_int;
    logic [15:0] w_im2_vec;

    int_sync2 u_nmi_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (nmi_n),
        .o_q    (w_nmi_q),
        .o_prev (w_nmi_prev)
    );

    int_sync2 u_int_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (int_n),
        .o_q    (w_int_q),
        .o_prev (w_int_prev)
    );

    assign w_nmi_fall = w_nmi_prev & ~w_nmi_q;
    // INT must be seen low on two samples so both paths share one latency.
    assign w_int_lvl  = ~w_int_q & ~w_int_prev;

    assign w_ack      = (r_state == REQ) & int_ack;
    assign w_take_nmi = r_nmi_pend & (r_state != REQ);
    // An ei/di retiring this cycle changes IFF1; do not race it.
    assign w_take_int = ~r_nmi_pend & w_int_lvl & r_iff1
                      & (r_state == RUN) & ~ei & ~di;

    // IM2 table entry is always even: bit 0 of the device byte is dropped.
    assign w_im2_vec  = {i_reg, vec_data} & 16'hFFFE;

    always_comb begin
        w_state_nx  = r_state;
        w_iff1_nx   = r_iff1;
        w_iff2_nx   = r_iff2;
        w_im_nx     = r_im;
        w_req_nx    = r_req;
        w_is_nmi_nx = r_is_nmi;
        w_vec_nx    = r_vec;
        w_pend_nx   = r_nmi_pend | w_nmi_fall;

        unique case (r_state)
            RUN: begin
                if (w_take_nmi || w_take_int) begin
                    w_state_nx = REQ;
                end else if (ei) begin
                    w_state_nx = EI_WAIT;
                end
            end
            EI_WAIT: begin
                if (w_take_nmi) begin
                    w_state_nx = REQ;
                end else if (instr_retire && !ei) begin
                    w_state_nx = RUN;
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_state_nx = RUN;
                end
            end
            default: w_state_nx = RUN;
        endcase

        if (w_take_nmi || w_take_int) begin
            w_req_nx    = 1'b1;
            w_is_nmi_nx = w_take_nmi;
            if (w_take_nmi) begin
                w_vec_nx = NMI_VEC;
            end else if (r_im == IM_2) begin
                w_vec_nx = w_im2_vec;
            end else begin
                w_vec_nx = RST38_VEC;
            end
        end

        // Retire pulses sharing the ack cycle belong to flushed instructions.
        if (w_ack) begin
            w_req_nx    = 1'b0;
            w_is_nmi_nx = 1'b0;
            if (r_is_nmi) begin
                w_iff2_nx = r_iff1;
                w_iff1_nx = 1'b0;
                w_pend_nx = 1'b0;
            end else begin
                w_iff1_nx = 1'b0;
                w_iff2_nx = 1'b0;
            end
        end else begin
            if (di) begin
                w_iff1_nx = 1'b0;
                w_iff2_nx = 1'b0;
            end else if (ei) begin
                w_iff1_nx = 1'b1;
                w_iff2_nx = 1'b1;
            end else if (retn) begin
                w_iff1_nx = r_iff2;
            end
            if (im_wr) begin
                w_im_nx = im_norm(im_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_iff1     <= 1'b0;
            r_iff2     <= 1'b0;
            r_im       <= IM_0;
            r_req      <= 1'b0;
            r_is_nmi   <= 1'b0;
            r_vec      <= 16'h0000;
            r_nmi_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_iff1     <= w_iff1_nx;
            r_iff2     <= w_iff2_nx;
            r_im       <= w_im_nx;
            r_req      <= w_req_nx;
            r_is_nmi   <= w_is_nmi_nx;
            r_vec      <= w_vec_nx;
            r_nmi_pend <= w_pend_nx;
        end
    end

    assign int_req    = r_req;
    assign int_is_nmi = r_is_nmi;
    assign int_vector = r_vec;
    assign IFF1       = r_iff1;
    assign IFF2       = r_iff2;
    assign im         = r_im;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Self-checking bench for z80_int_ctrl: vector table plus directed sequences.
// Latency expectations follow INT_SYNC_EN when it is defined.
module tb_z80_int_ctrl;

`ifdef INT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nmi_n, int_n;
    logic        ei, di, retn, im_wr;
    logic [1:0]  im_data;
    logic        instr_retire;
    logic [7:0]  i_reg, vec_data;
    logic        int_ack;
    logic        int_req, int_is_nmi;
    logic [15:0] int_vector;
    logic        IFF1, IFF2;
    logic [1:0]  im;

    int total = 0;
    int bad   = 0;

    z80_int_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nmi_n        (nmi_n),
        .int_n        (int_n),
        .ei           (ei),
        .di           (di),
        .retn         (retn),
        .im_wr        (im_wr),
        .im_data      (im_data),
        .instr_retire (instr_retire),
        .i_reg        (i_reg),
        .vec_data     (vec_data),
        .int_ack      (int_ack),
        .int_req      (int_req),
        .int_is_nmi   (int_is_nmi),
        .int_vector   (int_vector),
        .IFF1         (IFF1),
        .IFF2         (IFF2),
        .im           (im)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ei, di, retn, imw;
        logic [1:0] imd;
        logic       ret;
        logic       e_iff1, e_iff2;
        logic [1:0] e_im;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulses();
        ei = 0; di = 0; retn = 0; im_wr = 0;
        instr_retire = 0; int_ack = 0;
    endtask

    task automatic pulse_ei_retire();
        ei = 1; tick(); ei = 0;
        instr_retire = 1; tick(); instr_retire = 0;
    endtask

    // Caller has just driven a line low: check the exact rise point.
    task automatic wait_req(input string nm);
        tick(LAT);
        chk({nm, "_early"}, {31'd0, int_req}, 32'd0);
        tick();
        chk({nm, "_req"}, {31'd0, int_req}, 32'd1);
    endtask

    task automatic ack();
        int_ack = 1; tick(); int_ack = 0;
    endtask

    initial begin
        rst_n = 0; nmi_n = 1; int_n = 1;
        im_data = 0; i_reg = 0; vec_data = 0;
        clr_pulses();

        tbl[0]  = '{0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0};
        tbl[1]  = '{1, 0, 0, 0, 2'd0, 0, 1, 1, 2'd0};
        tbl[2]  = '{0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0};
        tbl[3]  = '{1, 0, 0, 0, 2'd0, 0, 1, 1, 2'd0};
        tbl[4]  = '{0, 0, 0, 0, 2'd0, 1, 1, 1, 2'd0};
        tbl[5]  = '{0, 0, 0, 1, 2'd2, 0, 1, 1, 2'd2};
        tbl[6]  = '{0, 0, 0, 1, 2'd3, 0, 1, 1, 2'd0};
        tbl[7]  = '{1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0};
        tbl[8]  = '{1, 0, 1, 0, 2'd0, 0, 1, 1, 2'd0};
        tbl[9]  = '{0, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0};
        tbl[10] = '{1, 0, 0, 1, 2'd1, 0, 1, 1, 2'd1};
        tbl[11] = '{0, 0, 0, 0, 2'd0, 1, 1, 1, 2'd1};

        tick(2);
        rst_n = 1;
        chk("rst_req", {31'd0, int_req}, 32'd0);
        chk("rst_nmi", {31'd0, int_is_nmi}, 32'd0);
        chk("rst_vec", {16'd0, int_vector}, 32'd0);
        chk("rst_iff", {30'd0, IFF1, IFF2}, 32'd0);
        chk("rst_im", {30'd0, im}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            ei = tbl[i].ei; di = tbl[i].di; retn = tbl[i].retn;
            im_wr = tbl[i].imw; im_data = tbl[i].imd;
            instr_retire = tbl[i].ret;
            tick();
            clr_pulses();
            chk($sformatf("tbl%0d", i), {27'd0, IFF1, IFF2, im, int_req},
                {27'd0, tbl[i].e_iff1, tbl[i].e_iff2, tbl[i].e_im, 1'b0});
        end

        // IM1 maskable request, held after int_n releases, then acked.
        int_n = 0;
        wait_req("im1");
        chk("im1_vec", {16'd0, int_vector}, 32'h0038);
        chk("im1_nmi", {31'd0, int_is_nmi}, 32'd0);
        int_n = 1;
        tick(3);
        chk("im1_hold", {31'd0, int_req}, 32'd1);
        ack();
        chk("im1_ack", {30'd0, IFF1, IFF2, int_req}, 32'd0);

        // EI shadow: level INT ignored until the next retire.
        ei = 1; tick(); ei = 0;
        int_n = 0;
        tick(LAT + 4);
        chk("eiw_block", {31'd0, int_req}, 32'd0);
        instr_retire = 1; tick(); instr_retire = 0;
        chk("eiw_retire", {31'd0, int_req}, 32'd0);
        tick();
        chk("eiw_req", {31'd0, int_req}, 32'd1);
        int_n = 1;
        ack();
        chk("eiw_ack", {30'd0, IFF1, IFF2}, 32'd0);

        // NMI: IFF1 saved into IFF2, restored by retn.
        pulse_ei_retire();
        nmi_n = 0;
        wait_req("nmi");
        chk("nmi_flag", {31'd0, int_is_nmi}, 32'd1);
        chk("nmi_vec", {16'd0, int_vector}, 32'h0066);
        ack();
        chk("nmi_ack", {29'd0, IFF1, IFF2, int_req}, 32'b010);
        tick(3);
        chk("nmi_once", {31'd0, int_req}, 32'd0);
        nmi_n = 1;
        tick(LAT + 1);
        retn = 1; tick(); retn = 0;
        chk("retn", {30'd0, IFF1, IFF2}, 32'b11);

        // IM2 vector from I and device byte, stable while unacked.
        im_wr = 1; im_data = 2'd2; tick(); im_wr = 0;
        i_reg = 8'h3A; vec_data = 8'hF7;
        int_n = 0;
        wait_req("im2");
        chk("im2_vec", {16'd0, int_vector}, 32'h3AF6);
        i_reg = 8'h00; vec_data = 8'h00; int_n = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("im2_hold%0d", c), {15'd0, int_req, int_vector},
                {15'd0, 1'b1, 16'h3AF6});
        end
        ack();
        chk("im2_ack", {29'd0, IFF1, IFF2, int_req}, 32'd0);

        // NMI and INT together: NMI first, INT then masked by IFF1=0.
        pulse_ei_retire();
        im_wr = 1; im_data = 2'd1; tick(); im_wr = 0;
        nmi_n = 0; int_n = 0;
        wait_req("both");
        chk("both_nmi", {15'd0, int_is_nmi, int_vector},
            {15'd0, 1'b1, 16'h0066});
        ack();
        chk("both_ack", {30'd0, IFF1, IFF2}, 32'b01);
        tick(3);
        chk("both_noint", {31'd0, int_req}, 32'd0);
        nmi_n = 1; int_n = 1;
        tick(LAT + 1);

        // di with ack is flushed; ack clears IFFs.
        pulse_ei_retire();
        int_n = 0;
        wait_req("di_ack");
        int_n = 1;
        int_ack = 1; di = 1; tick(); clr_pulses();
        chk("di_ack", {29'd0, IFF1, IFF2, int_req}, 32'd0);

        // ei and im_wr with ack are flushed too.
        pulse_ei_retire();
        int_n = 0;
        wait_req("ei_ack");
        int_n = 1;
        int_ack = 1; ei = 1; im_wr = 1; im_data = 2'd2;
        tick(); clr_pulses();
        chk("ei_ack", {27'd0, IFF1, IFF2, im, int_req}, {27'd0, 5'b00010});

        // Reset during an open request.
        pulse_ei_retire();
        int_n = 0;
        wait_req("rst_mid");
        rst_n = 0; tick();
        chk("rstm_out", {12'd0, int_req, int_is_nmi, int_vector, IFF1, IFF2},
            32'd0);
        chk("rstm_im", {30'd0, im}, 32'd0);
        int_n = 1; tick(); rst_n = 1; tick(2);
        chk("rstm_idle", {31'd0, int_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
